v810_prefetch: RTL and testbench

Instruction prefetch queue inserted between the `v810_exec` instruction port and the `v810_mem` instruction port. It fetches aligned 32-bit words ahead of the execution unit and holds them in a small FIFO. It serves sequential instruction requests, including halfword-misaligned 32-bit fetches, with zero wait states on a hit. On a non-sequential request (branch, exception vector) it flushes and refetches.

---
 rtl/v810_prefetch.sv | 112 +++++++++++
 tb/tb_v810_prefetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/v810_prefetch.sv
// Instruction prefetch queue between the v810 EU and memory instruction ports.
// Keeps aligned words ahead of the EU; sequential fetches hit with zero wait states.
module v810_prefetch #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [31:0] IA,
  input  logic        IREQ,
  output logic [31:0] ID,
  output logic        IACK,
  output logic [31:0] MIA,
  output logic        MIREQ,
  input  logic [31:0] MID,
  input  logic        MIACK
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [29:0] QA_RST = 30'h3FFFFFFC;

  logic [29:0]   qa_q, qa_d;
  logic [AW-1:0] hd_q, hd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          disc_q, disc_d;
  logic          mireq_q, mireq_d;
  logic [29:0]   mia_q, mia_d;
  logic [31:0]   buf_q [DEPTH];

  logic [29:0]   ofs;
  logic [CW-1:0] ofs_c, avail;
  logic [AW-1:0] i0, i1, wr_idx;
  logic          hit, miss, ack, ack_mem, wr_en;
  logic          unused_ia0;

  assign unused_ia0 = IA[0];

  // Word offset of the request from the queue head, modulo 2^30.
  assign ofs    = IA[31:2] - qa_q;
  assign ofs_c  = ofs[CW-1:0];
  assign hit    = ofs <= 30'(cnt_q);
  assign miss   = IREQ && !hit;
  assign avail  = cnt_q - ofs_c;
  assign i0     = hd_q + ofs[AW-1:0];
  assign i1     = i0 + AW'(1);
  assign wr_idx = hd_q + cnt_q[AW-1:0];

  assign ack     = CE && IREQ && hit && (IA[1] ? (avail >= CW'(2)) : (avail >= CW'(1)));
  // The memory request flag doubles as the "fetch in flight" state.
  assign ack_mem = CE && MIACK && mireq_q;
  assign wr_en   = ack_mem && !disc_q && !miss;

  always_comb begin
    qa_d    = qa_q;
    hd_d    = hd_q;
    cnt_d   = cnt_q;
    disc_d  = disc_q;
    mireq_d = mireq_q;
    mia_d   = mia_q;
    if (ack_mem) begin
      mireq_d = 1'b0;
      disc_d  = 1'b0;
    end
    if (miss) begin
      qa_d   = IA[31:2];
      hd_d   = '0;
      cnt_d  = '0;
      disc_d = mireq_q && !ack_mem;
    end else begin
      if (IREQ) begin
        qa_d  = qa_q + ofs;
        hd_d  = hd_q + ofs[AW-1:0];
        cnt_d = cnt_q - ofs_c;
      end
      if (wr_en) cnt_d = cnt_d + CW'(1);
    end
    // A new fetch only starts from an idle port, so nothing is in flight here.
    if (!mireq_q && (cnt_d < CW'(DEPTH))) begin
      mireq_d = 1'b1;
      mia_d   = qa_d + 30'(cnt_d);
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      qa_q    <= QA_RST;
      hd_q    <= '0;
      cnt_q   <= '0;
      disc_q  <= 1'b0;
      mireq_q <= 1'b0;
      mia_q   <= QA_RST;
    end else if (CE) begin
      qa_q    <= qa_d;
      hd_q    <= hd_d;
      cnt_q   <= cnt_d;
      disc_q  <= disc_d;
      mireq_q <= mireq_d;
      mia_q   <= mia_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RES && wr_en) buf_q[wr_idx] <= MID;
  end

  assign IACK  = ack;
  assign ID    = !ack ? 32'h0 :
                 IA[1] ? {buf_q[i1][15:0], buf_q[i0][31:16]} : buf_q[i0];
  assign MIA   = {mia_q, 2'b00};
  assign MIREQ = mireq_q;

endmodule

// File: tb/tb_v810_prefetch.sv
// Scoreboard bench for v810_prefetch: directed fetches push expected ID words,
// a negedge monitor pops and compares on every IACK.
module tb_v810_prefetch;
  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        CE = 1'b1;
  logic        IREQ = 1'b0;
  logic        MIACK = 1'b0;
  logic        IACK, MIREQ;
  logic [31:0] IA = 32'h0;
  logic [31:0] MID = 32'h0;
  logic [31:0] ID, MIA;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int mem_lat = 0;
  int last_ack_cyc = -1;
  bit ce_tog = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] mia_log[$];

  v810_prefetch #(.DEPTH(4)) dut (
    .CLK(CLK), .RES(RES), .CE(CE), .IA(IA), .IREQ(IREQ), .ID(ID), .IACK(IACK),
    .MIA(MIA), .MIREQ(MIREQ), .MID(MID), .MIACK(MIACK)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'hFFFFFFF0) return 32'h11112222;
    if (a == 32'hFFFFFFF4) return 32'h33334444;
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Memory model: acks after mem_lat CE cycles of MIREQ; only CE cycles count.
  initial begin
    int lat_cnt = 0;
    forever begin
      @(posedge CLK); #2;
      MIACK = 1'b0;
      MID   = 32'h0;
      if (MIREQ && !RES) begin
        if (CE) begin
          if (lat_cnt >= mem_lat) begin
            MIACK = 1'b1;
            MID = word(MIA);
            lat_cnt = 0;
            last_ack_cyc = cyc;
          end else lat_cnt++;
        end
      end else lat_cnt = 0;
    end
  end

  initial begin
    forever begin
      @(posedge CLK); #1;
      if (ce_tog) CE = ~CE;
      else CE = 1'b1;
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge CLK);
      if (IACK) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_iack: got ID %08h, expected no IACK", ID);
        end else check("id", ID, exp_q.pop_front());
        check("iack_needs_ce", 32'(CE), 32'd1);
      end else check("id_idle_zero", ID, 32'h0);
      if (MIACK && MIREQ && CE && !RES) mia_log.push_back(MIA);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int k);
    repeat (k) @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] e,
                       output int n, output int n_ce, output int ack_cyc);
    exp_q.push_back(e);
    IA = a;
    IREQ = 1'b1;
    n = 0;
    n_ce = 0;
    ack_cyc = -1;
    forever begin
      @(negedge CLK);
      if (IACK) begin
        ack_cyc = cyc;
        break;
      end
      n++;
      if (CE) n_ce++;
      if (n > 60) begin
        n_chk++;
        n_fail++;
        $display("FAIL fetch_timeout: IA %08h no IACK after %0d cycles, expected IACK", a, n);
        void'(exp_q.pop_back());
        break;
      end
    end
    @(posedge CLK); #1;
    IREQ = 1'b0;
  endtask

  initial begin
    int n, nce, ac;
    idle(3);
    @(negedge CLK);
    check("rst_mireq", 32'(MIREQ), 32'd0);
    check("rst_mia", MIA, 32'hFFFFFFF0);
    check("rst_iack", 32'(IACK), 32'd0);
    @(posedge CLK); #1;
    RES = 1'b0;
    @(negedge CLK);
    check("mireq_low_first_cycle", 32'(MIREQ), 32'd0);
    @(negedge CLK);
    check("mireq_rise", 32'(MIREQ), 32'd1);
    check("mia_first", MIA, 32'hFFFFFFF0);
    idle(20);
    check("fill_count", 32'(mia_log.size()), 32'd4);
    check("fill_mia0", mia_log[0], 32'hFFFFFFF0);
    check("fill_mia3", mia_log[3], 32'hFFFFFFFC);
    check("full_mireq_low", 32'(MIREQ), 32'd0);

    // Sequential hits, halfword misalignment, drop with coincident MIACK, wrap.
    fetch(32'hFFFFFFF0, 32'h11112222, n, nce, ac); check("hit_f0_lat", n, 0);
    fetch(32'hFFFFFFF2, 32'h44441111, n, nce, ac); check("hit_f2_lat", n, 0);
    fetch(32'hFFFFFFF4, 32'h33334444, n, nce, ac); check("hit_f4_lat", n, 0);
    fetch(32'hFFFFFFF8, 32'h3F26FFF8, n, nce, ac); check("hit_f8_lat", n, 0);
    fetch(32'hFFFFFFFE, 32'h00003F22, n, nce, ac); check("hit_fe_lat", n, 0);
    idle(10);
    check("wrap_count", 32'(mia_log.size()), 32'd7);
    check("wrap_mia4", mia_log[4], 32'h00000000);
    check("coincident_mia5", mia_log[5], 32'h00000004);
    check("wrap_mia6", mia_log[6], 32'h00000008);

    // Branch miss while a slow fetch is in flight.
    mem_lat = 3;
    fetch(32'h00000000, 32'hC0DE0000, n, nce, ac); check("hit_00_lat", n, 0);
    idle(1);
    fetch(32'h00001000, 32'hD0DE1000, n, nce, ac);
    check("branch_lat", n, 8);
    check("branch_iack_after_miack", ac, last_ack_cyc + 1);
    check("branch_discarded_mia", mia_log[mia_log.size()-2], 32'h0000000C);
    check("branch_new_mia", mia_log[mia_log.size()-1], 32'h00001000);

    // Misaligned request after a flush needs two words.
    mem_lat = 0;
    idle(12);
    fetch(32'h00002002, 32'h2004E0DE, n, nce, ac);
    check("misaligned_lat", n, 4);
    check("misaligned_iack_after_miack", ac, last_ack_cyc + 1);
    idle(12);

    // Half-rate clock enable across a hit and a miss.
    ce_tog = 1'b1;
    fetch(32'h00002004, 32'hE0DA2004, n, nce, ac);
    check("ce_hit_lat", nce, 0);
    idle(16);
    fetch(32'h00003000, 32'hF0DE3000, n, nce, ac);
    check("ce_miss_lat", nce, 2);
    ce_tog = 1'b0;

    // Reset with a fetch in flight.
    mem_lat = 3;
    idle(2);
    RES = 1'b1;
    idle(2);
    @(negedge CLK);
    check("rst2_mireq", 32'(MIREQ), 32'd0);
    check("rst2_mia", MIA, 32'hFFFFFFF0);
    @(posedge CLK); #1;
    RES = 1'b0;
    mem_lat = 0;
    idle(20);
    fetch(32'hFFFFFFF2, 32'h44441111, n, nce, ac); check("post_rst_hit_lat", n, 0);
    idle(2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
